dekatron_counter: RTL and testbench

Multi-digit one-hot decade counter, the parametrised successor of the single Dekatron ring. Chains DIGITS rings of RADIX positions with ripple carry/borrow: one digit advances per clock, the way a physical dekatron chain propagates. Adds a ready/done handshake, parallel load with one-hot validation, and overflow/underflow reporting. Serves as the IP/AP register model in the DekatronPC core.

---
 rtl/dekatron_counter.sv | 90 +++++++++
 tb/tb_dekatron_counter.sv | 78 +++++++
 2 files changed

// File: rtl/dekatron_counter.sv
// dekatron_counter: chained one-hot decade rings with ripple carry/borrow, one digit per clock
// Ports: Clk/Rst (sync, active-high); Step/Reverse/Set/In accepted only while Ready;
// Out packs digit d at [d*RADIX +: RADIX]; Done/Overflow/Err are one-cycle pulses; Zero is combinational.
module dekatron_counter #(
  parameter int DIGITS = 3,
  parameter int RADIX  = 10
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Step,
  input  logic                     Reverse,
  input  logic                     Set,
  input  logic [DIGITS*RADIX-1:0]  In,
  output logic [DIGITS*RADIX-1:0]  Out,
  output logic                     Ready,
  output logic                     Done,
  output logic                     Overflow,
  output logic                     Err,
  output logic                     Zero
);
  localparam int W  = DIGITS * RADIX;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic {IDLE, CARRY} state_t;
  function automatic logic [W-1:0] zero_val();
    logic [W-1:0] z;
    z = '0;
    for (int k = 0; k < DIGITS; k++) z[k*RADIX] = 1'b1;
    return z;
  endfunction
  localparam logic [W-1:0] ZERO = zero_val();
  state_t            state_q;
  logic [IW-1:0]     idx_q, idx;
  logic              dir_q, dir, wrap, last, valid;
  logic              done_q, ovf_q, err_q;
  logic [W-1:0]      out_q;
  logic [RADIX-1:0]  dig, rot;
  logic [DIGITS-1:0] ok;
  int                base;
  for (genvar d = 0; d < DIGITS; d++) begin : g_chk
    assign ok[d] = $onehot(In[d*RADIX +: RADIX]);
  end
  // In IDLE the active digit is always digit 0 and the direction comes straight from the port.
  always_comb begin
    idx   = state_q == IDLE ? '0 : idx_q;
    dir   = state_q == IDLE ? Reverse : dir_q;
    base  = int'(idx) * RADIX;
    dig   = out_q[base +: RADIX];
    rot   = dir ? {dig[0], dig[RADIX-1:1]} : {dig[RADIX-2:0], dig[RADIX-1]};
    wrap  = dir ? dig[0] : dig[RADIX-1];
    last  = idx == IW'(DIGITS - 1);
    valid = &ok;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= ZERO;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == IDLE && Set) begin
        if (valid) out_q <= In;
        done_q <= valid;
        err_q  <= !valid;
      end else if (state_q == CARRY || Step) begin
        out_q[base +: RADIX] <= rot;
        if (state_q == IDLE) dir_q <= Reverse;
        if (wrap && !last) begin
          state_q <= CARRY;
          idx_q   <= idx + 1'b1;
        end else begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          ovf_q   <= wrap;
        end
      end
    end
  end
  assign Out      = out_q;
  assign Ready    = state_q == IDLE;
  assign Done     = done_q;
  assign Overflow = ovf_q;
  assign Err      = err_q;
  assign Zero     = out_q == ZERO;
endmodule

// File: tb/tb_dekatron_counter.sv
// tb_dekatron_counter: directed scoreboard bench for a 3-digit decade dekatron_counter
module tb_dekatron_counter;
  localparam int DIGITS = 3;
  localparam int RADIX  = 10;
  localparam int W      = DIGITS * RADIX;
  logic Clk = 1'b0, Rst = 1'b0, Step = 1'b0, Reverse = 1'b0, Set = 1'b0;
  logic [W-1:0] In = '0;
  logic [W-1:0] Out;
  logic Ready, Done, Overflow, Err, Zero;
  int vectors = 0, miscompares = 0;
  logic [W+4:0] exp_q[$];
  dekatron_counter #(.DIGITS(DIGITS), .RADIX(RADIX)) dut (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Reverse(Reverse), .Set(Set), .In(In),
    .Out(Out), .Ready(Ready), .Done(Done), .Overflow(Overflow), .Err(Err), .Zero(Zero)
  );
  always #5 Clk = ~Clk;
  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*RADIX + x % 10] = 1'b1;
      x = x / 10;
    end
    return r;
  endfunction
  task automatic cyc(input logic rst, st, rv, se, input logic [W-1:0] iv, input int eo,
                     input logic er, ed, eov, eerr, input string tag);
    logic [W+4:0] e, o;
    Rst = rst; Step = st; Reverse = rv; Set = se; In = iv;
    exp_q.push_back({enc(eo), er, ed, eov, eerr, eo == 0});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    o = {Out, Ready, Done, Overflow, Err, Zero};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed out=%h rdy/done/ovf/err/zero=%b expected out=%h rdy/done/ovf/err/zero=%b",
             tag, o[W+4:5], o[4:0], e[W+4:5], e[4:0]);
    end
  endtask
  initial begin
    logic [W-1:0] bad;
    cyc(1, 0, 0, 0, '0, 0, 1, 0, 0, 0, "reset");
    for (int i = 1; i <= 9; i++) cyc(0, 1, 0, 0, '0, i, 1, 1, 0, 0, "fwd_nocarry");
    cyc(0, 1, 0, 0, '0, 0, 0, 0, 0, 0, "c1_digit0");
    cyc(0, 0, 0, 0, '0, 10, 1, 1, 0, 0, "c1_digit1");
    cyc(0, 0, 0, 0, '0, 10, 1, 0, 0, 0, "c1_idle");
    cyc(0, 0, 0, 1, enc(999), 999, 1, 1, 0, 0, "set_999");
    cyc(0, 1, 0, 0, '0, 990, 0, 0, 0, 0, "ovf_n");
    cyc(0, 0, 0, 0, '0, 900, 0, 0, 0, 0, "ovf_n1");
    cyc(0, 0, 0, 0, '0, 0, 1, 1, 1, 0, "ovf_n2");
    cyc(0, 1, 1, 0, '0, 9, 0, 0, 0, 0, "rev_n");
    cyc(0, 1, 0, 0, '0, 99, 0, 0, 0, 0, "rev_toggle");
    cyc(0, 0, 0, 0, '0, 999, 1, 1, 1, 0, "rev_underflow");
    cyc(0, 0, 0, 0, '0, 999, 1, 0, 0, 0, "rev_idle");
    bad = enc(512);
    bad[19:10] = 10'h000;
    cyc(0, 0, 0, 1, bad, 999, 1, 0, 0, 1, "set_nobit");
    bad[19:10] = 10'h003;
    cyc(0, 0, 0, 1, bad, 999, 1, 0, 0, 1, "set_twobit");
    cyc(0, 0, 0, 1, enc(512), 512, 1, 1, 0, 0, "set_512");
    cyc(0, 0, 0, 1, enc(99), 99, 1, 1, 0, 0, "set_099");
    cyc(0, 1, 0, 0, '0, 90, 0, 0, 0, 0, "busy_n");
    cyc(0, 1, 0, 1, enc(555), 0, 0, 0, 0, 0, "busy_ignore1");
    cyc(0, 1, 0, 1, enc(555), 100, 1, 1, 0, 0, "busy_ignore2");
    cyc(0, 1, 0, 1, enc(321), 321, 1, 1, 0, 0, "set_over_step");
    cyc(0, 0, 0, 1, enc(199), 199, 1, 1, 0, 0, "set_199");
    cyc(0, 1, 0, 0, '0, 190, 0, 0, 0, 0, "rst_carry_n");
    cyc(1, 0, 0, 0, '0, 0, 1, 0, 0, 0, "rst_in_carry");
    cyc(0, 0, 0, 0, '0, 0, 1, 0, 0, 0, "rst_quiet");
    cyc(0, 1, 0, 0, '0, 1, 1, 1, 0, 0, "post_rst_step");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
